// File: rtl/gpu_pkg.sv
// Shared GPU definitions: channel/brightness defaults, fade FSM states and
// the bus half-select encoding used by the palette color RAM.
package gpu_pkg;
    localparam int CHAN_W_DEF   = 8;
    localparam int BRIGHT_W_DEF = 8;

    typedef enum logic {
        FADE_IDLE   = 1'b0,
        FADE_ACTIVE = 1'b1
    } fade_state_e;

    // memaddr[0] selects which half of a palette entry the bus word maps to
    localparam logic HALF_GR = 1'b0;
    localparam logic HALF_B  = 1'b1;
endpackage

// File: rtl/palette_scale.sv
// One color channel scaled by brightness: (ch * (bright+1)) >> BRIGHT_W, registered.
module palette_scale
    import gpu_pkg::*;
#(
    parameter int CHAN_W   = CHAN_W_DEF,
    parameter int BRIGHT_W = BRIGHT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [CHAN_W-1:0]   ch_i,
    input  logic [BRIGHT_W-1:0] bright_i,
    output logic [CHAN_W-1:0]   ch_o
);
    localparam int PW = CHAN_W + BRIGHT_W + 1;

    logic [PW-1:0]     prod;
    logic [CHAN_W-1:0] ch_q;

    // bright+1 makes full brightness an exact identity and 0 always black
    assign prod = PW'(ch_i) * PW'({1'b0, bright_i} + (BRIGHT_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ch_q <= '0;
        else if (valid_i) ch_q <= CHAN_W'(prod >> BRIGHT_W);
        else              ch_q <= '0;
    end

    assign ch_o = ch_q;
endmodule

// File: rtl/palette_fader.sv
// Palette lookup with per-frame brightness fade engine; 2-cycle pixel pipe,
// host-writable color RAM on a 16-bit word bus.
module palette_fader
    import gpu_pkg::*;
#(
    parameter int                    PAL_BITS     = 5,
    parameter int                    COLOR_BITS   = 4,
    parameter int                    CHAN_W       = CHAN_W_DEF,
    parameter int                    BRIGHT_W     = BRIGHT_W_DEF,
    parameter logic [BRIGHT_W-1:0]   RESET_BRIGHT = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic [PAL_BITS+COLOR_BITS-1:0] index,
    output logic                          out_valid,
    output logic [CHAN_W-1:0]             red,
    output logic [CHAN_W-1:0]             green,
    output logic [CHAN_W-1:0]             blue,
    input  logic                          frame_tick,
    input  logic                          fade_start,
    input  logic [BRIGHT_W-1:0]           fade_target,
    input  logic [BRIGHT_W-1:0]           fade_step,
    input  logic                          bright_load,
    input  logic [BRIGHT_W-1:0]           bright_in,
    output logic [BRIGHT_W-1:0]           brightness,
    output logic                          fade_busy,
    output logic                          fade_done,
    input  logic                          memenable,
    input  logic [PAL_BITS+COLOR_BITS:0]  memaddr,
    input  logic                          memwrite,
    input  logic [15:0]                   writedata,
    output logic [15:0]                   memdata
);
    localparam int IW      = PAL_BITS + COLOR_BITS;
    localparam int ENTRIES = 1 << IW;

    logic [CHAN_W-1:0] ram_r [ENTRIES];
    logic [CHAN_W-1:0] ram_g [ENTRIES];
    logic [CHAN_W-1:0] ram_b [ENTRIES];

    logic [IW-1:0]           bus_ent;
    logic [15:0]             memdata_d, memdata_q;
    logic [2:0][CHAN_W-1:0]  rgb_s1, rgb_s2;
    logic [2:1]              vld_q;

    assign bus_ent = memaddr[IW:1];

    // Bus port; read data is taken before the write lands (read-first)
    always_ff @(posedge clk) begin
        if (memenable && memwrite) begin
            if (memaddr[0] == HALF_GR) begin
                ram_r[bus_ent] <= writedata[CHAN_W-1:0];
                ram_g[bus_ent] <= writedata[8 +: CHAN_W];
            end else begin
                ram_b[bus_ent] <= writedata[CHAN_W-1:0];
            end
        end
    end

    always_comb begin
        memdata_d = {8'(ram_g[bus_ent]), 8'(ram_r[bus_ent])};
        if (memaddr[0] == HALF_B) memdata_d = {8'h00, 8'(ram_b[bus_ent])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     memdata_q <= '0;
        else if (memenable && !memwrite) memdata_q <= memdata_d;
    end

    // Pixel port: stage 1 RAM data
    always_ff @(posedge clk) begin
        rgb_s1[0] <= ram_r[index];
        rgb_s1[1] <= ram_g[index];
        rgb_s1[2] <= ram_b[index];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {vld_q[1], pix_valid};
    end

    fade_state_e           state_q, state_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d, target_q, target_d, step_q, step_d;
    logic [BRIGHT_W-1:0]   stepped;
    logic [BRIGHT_W:0]     up_sum, dn_diff;
    logic                  done_q, done_d;

    generate
        for (genvar c = 0; c < 3; c++) begin : g_ch
            palette_scale #(.CHAN_W(CHAN_W), .BRIGHT_W(BRIGHT_W)) u_scale (
                .clk      (clk),
                .rst_n    (rst_n),
                .valid_i  (vld_q[1]),
                .ch_i     (rgb_s1[c]),
                .bright_i (bright_q),
                .ch_o     (rgb_s2[c])
            );
        end
    endgenerate

    // One saturating step toward target, computed one bit wider than brightness
    always_comb begin
        up_sum  = {1'b0, bright_q} + {1'b0, step_q};
        dn_diff = {1'b0, bright_q} - {1'b0, step_q};
        stepped = target_q;
        if (step_q != '0 && bright_q < target_q) begin
            if (up_sum < {1'b0, target_q}) stepped = up_sum[BRIGHT_W-1:0];
        end else if (step_q != '0 && bright_q > target_q) begin
            if (!dn_diff[BRIGHT_W] && dn_diff > {1'b0, target_q}) stepped = dn_diff[BRIGHT_W-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        target_d = target_q;
        step_d   = step_q;
        done_d   = 1'b0;
        if (fade_start) begin
            state_d  = FADE_ACTIVE;
            target_d = fade_target;
            step_d   = fade_step;
        end else if (state_q == FADE_IDLE) begin
            if (bright_load) bright_d = bright_in;
        end else if (frame_tick) begin
            bright_d = stepped;
            if (stepped == target_q) begin
                state_d = FADE_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FADE_IDLE;
            bright_q <= RESET_BRIGHT;
            target_q <= '0;
            step_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            target_q <= target_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    assign out_valid  = vld_q[2];
    assign red        = rgb_s2[0];
    assign green      = rgb_s2[1];
    assign blue       = rgb_s2[2];
    assign brightness = bright_q;
    assign fade_busy  = (state_q == FADE_ACTIVE);
    assign fade_done  = done_q;
    assign memdata    = memdata_q;
endmodule

// File: tb/tb_palette_fader.sv
// Directed-vector bench for palette_fader: bus map, scaling, fade FSM, reset, pipe.
module tb_palette_fader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [8:0]  index;
    logic        out_valid;
    logic [7:0]  red, green, blue;
    logic        frame_tick, fade_start, bright_load;
    logic [7:0]  fade_target, fade_step, bright_in, brightness;
    logic        fade_busy, fade_done;
    logic        memenable, memwrite;
    logic [9:0]  memaddr;
    logic [15:0] writedata, memdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    palette_fader dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .index(index),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick), .fade_start(fade_start), .fade_target(fade_target),
        .fade_step(fade_step), .bright_load(bright_load), .bright_in(bright_in),
        .brightness(brightness), .fade_busy(fade_busy), .fade_done(fade_done),
        .memenable(memenable), .memaddr(memaddr), .memwrite(memwrite),
        .writedata(writedata), .memdata(memdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [9:0] a, input logic [15:0] d);
        memenable = 1'b1; memwrite = 1'b1; memaddr = a; writedata = d;
        step();
        memenable = 1'b0; memwrite = 1'b0;
    endtask

    task automatic bus_rd(input logic [9:0] a);
        memenable = 1'b1; memwrite = 1'b0; memaddr = a;
        step();
        memenable = 1'b0;
    endtask

    task automatic pix(input logic [8:0] idx);
        pix_valid = 1'b1; index = idx;
        step();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic load(input logic [7:0] b);
        bright_load = 1'b1; bright_in = b;
        step();
        bright_load = 1'b0;
    endtask

    task automatic start(input logic [7:0] t, input logic [7:0] s);
        fade_start = 1'b1; fade_target = t; fade_step = s;
        step();
        fade_start = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; index = '0; frame_tick = 1'b0;
        fade_start = 1'b0; fade_target = '0; fade_step = '0;
        bright_load = 1'b0; bright_in = '0;
        memenable = 1'b0; memwrite = 1'b0; memaddr = '0; writedata = '0;
        repeat (3) step();
        chk("rst_bright", brightness, 8'h00);
        chk("rst_busy", fade_busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rgb", {red, green, blue}, 24'h0);
        chk("rst_memdata", memdata, 16'h0);
        chk("rst_done", fade_done, 1'b0);
        rst_n = 1'b1;
        step();

        bus_wr(10'h046, 16'h4080);
        bus_wr(10'h047, 16'h00FF);
        bus_rd(10'h046);
        chk("rd_gr", memdata, 16'h4080);
        bus_rd(10'h047);
        chk("rd_b", memdata, 16'h00FF);
        step();
        chk("rd_hold", memdata, 16'h00FF);

        load(8'hFF);
        chk("load_ff", brightness, 8'hFF);
        pix(9'h023);
        chk("pix_ff_valid", out_valid, 1'b1);
        chk("pix_ff_rgb", {red, green, blue}, 24'h8040FF);
        load(8'h7F);
        pix(9'h023);
        chk("pix_7f_rgb", {red, green, blue}, 24'h40207F);
        load(8'h00);
        pix(9'h023);
        chk("pix_00_valid", out_valid, 1'b1);
        chk("pix_00_rgb", {red, green, blue}, 24'h000000);
        load(8'hFF);
        step();
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_rgb", {red, green, blue}, 24'h000000);
        load(8'h00);

        // start wins over load, and a same-cycle tick is deferred
        bright_load = 1'b1; bright_in = 8'h11; frame_tick = 1'b1;
        start(8'hFF, 8'h40);
        bright_load = 1'b0; frame_tick = 1'b0;
        chk("start_busy", fade_busy, 1'b1);
        chk("start_bright", brightness, 8'h00);
        load(8'h11);
        chk("fading_noload", brightness, 8'h00);
        ftick(); chk("fade1", brightness, 8'h40);
        ftick(); chk("fade2", brightness, 8'h80);
        ftick(); chk("fade3", brightness, 8'hC0);
        chk("fade3_done", fade_done, 1'b0);
        ftick(); chk("fade4", brightness, 8'hFF);
        chk("fade4_done", fade_done, 1'b1);
        chk("fade4_busy", fade_busy, 1'b0);
        step();
        chk("done_pulse", fade_done, 1'b0);

        start(8'h30, 8'h00);
        ftick();
        chk("jump_bright", brightness, 8'h30);
        chk("jump_done", fade_done, 1'b1);
        start(8'h10, 8'h40);
        ftick();
        chk("down_sat", brightness, 8'h10);
        start(8'h10, 8'h05);
        chk("eq_busy", fade_busy, 1'b1);
        ftick();
        chk("eq_done", fade_done, 1'b1);
        chk("eq_bright", brightness, 8'h10);

        start(8'h80, 8'h10);
        ftick();
        chk("relatch_pre", brightness, 8'h20);
        start(8'h00, 8'h08);
        chk("relatch_busy", fade_busy, 1'b1);
        chk("relatch_nodone", fade_done, 1'b0);
        ftick();
        chk("relatch_step", brightness, 8'h18);

        pix_valid = 1'b1; index = 9'h023;
        step(); step();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bright", brightness, 8'h00);
        chk("arst_busy", fade_busy, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        pix_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        load(8'hFF);
        memenable = 1'b1; memwrite = 1'b1; memaddr = 10'h046; writedata = 16'h1122;
        pix_valid = 1'b1; index = 9'h023;
        step();
        memenable = 1'b0; memwrite = 1'b0; pix_valid = 1'b0;
        step();
        chk("coll_old", {red, green, blue}, 24'h8040FF);
        pix(9'h023);
        chk("coll_new", {red, green, blue}, 24'h2211FF);
        bus_rd(10'h046);
        chk("coll_rd", memdata, 16'h1122);

        for (int i = 0; i < 64; i++) bus_wr(10'(i * 2), 16'(i * 3 + 1));
        begin
            int n_vld = 0;
            int n_ok  = 0;
            for (int c = 0; c < 66; c++) begin
                if (c < 64) begin
                    pix_valid = 1'b1; index = 9'(c);
                end else begin
                    pix_valid = 1'b0;
                end
                step();
                if (out_valid) n_vld++;
                if (c >= 1 && c <= 64 && out_valid && red == 8'((c - 1) * 3 + 1)) n_ok++;
            end
            chk("stream_count", n_vld, 64);
            chk("stream_order", n_ok, 64);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
